mem_arbiter: RTL

- Two-requester arbiter in front of the single-port `memory` block: port 0 is instruction fetch, port 1 is load/store.
- Captures one request at a time, issues it on the memory valid/ready interface and routes the single response back to the originator.
- At most one transaction is outstanding at the memory.
- Sits between the core front-end/LSU and `memory`; the memory instance is wired directly to the mem_* ports.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_pick.sv | 29 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM encoding, port IDs and memory command/width macros
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 2'd0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 2'd1
`endif

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_FETCH = 1'b0;
  localparam logic ARB_PORT_LSU   = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - grant selection; MEM_ARBITER_RR_EN selects round-robin, else fixed priority LSU over fetch
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_port_o
);

  assign gnt_valid_o = |valid_i;

`ifdef MEM_ARBITER_RR_EN
  // On contention the port granted last loses.
  always_comb begin
    gnt_port_o = ARB_PORT_FETCH;
    if (&valid_i) begin
      gnt_port_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      gnt_port_o = ARB_PORT_LSU;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign gnt_port_o = valid_i[1] ? ARB_PORT_LSU : ARB_PORT_FETCH;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of the single-port memory, one transaction outstanding
// Optional round-robin selection via MEM_ARBITER_RR_EN (handled in mem_arbiter_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = `ADDRESS_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int CMD_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [CMD_W-1:0]  p0_cmd,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_res_valid,
  input  logic              p0_res_ready,
  output logic [DATA_W-1:0] p0_res_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [CMD_W-1:0]  p1_cmd,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_res_valid,
  input  logic              p1_res_ready,
  output logic [DATA_W-1:0] p1_res_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [CMD_W-1:0]  mem_cmd,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_res_valid,
  output logic              mem_res_ready,
  input  logic [DATA_W-1:0] mem_res_data
);

  arb_state_e        state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] data_q;

  logic pick_valid;
  logic pick_port;
  logic accept;
  logic in_wait;
  logic gnt_res_ready;

  mem_arbiter_pick u_pick (
    .valid_i      ({p1_valid, p0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (pick_valid),
    .gnt_port_o   (pick_port)
  );

  // Gated by reset so no requester sees ready while reset is asserted.
  assign accept   = reset && (state_q == IDLE) && pick_valid;
  assign p0_ready = accept && (pick_port == ARB_PORT_FETCH);
  assign p1_ready = accept && (pick_port == ARB_PORT_LSU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= ARB_PORT_FETCH;
      last_grant_q <= ARB_PORT_LSU;
      mem_valid_q  <= 1'b0;
      addr_q       <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q       <= pick_port ? p1_address : p0_address;
            cmd_q        <= pick_port ? p1_cmd     : p0_cmd;
            data_q       <= pick_port ? p1_data    : p0_data;
            grant_q      <= pick_port;
            last_grant_q <= pick_port;
            mem_valid_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_res_valid && mem_res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_address = addr_q;
  assign mem_cmd     = cmd_q;
  assign mem_data    = data_q;

  // Response path is purely combinational so it adds no latency.
  assign in_wait       = (state_q == WAIT);
  assign gnt_res_ready = (grant_q == ARB_PORT_LSU) ? p1_res_ready : p0_res_ready;
  assign mem_res_ready = in_wait && gnt_res_ready;
  assign p0_res_valid  = in_wait && (grant_q == ARB_PORT_FETCH) && mem_res_valid;
  assign p1_res_valid  = in_wait && (grant_q == ARB_PORT_LSU) && mem_res_valid;
  assign p0_res_data   = mem_res_data;
  assign p1_res_data   = mem_res_data;

endmodule
